// File: rtl/frame_config_ctrl.sv
// Configuration sequencer: assembles one frame column from a 32-bit word stream
// onto the FrameData rows, then fires a single-cycle one-hot FrameStrobe.
module frame_config_ctrl #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 16,
  parameter int NumColumns      = 8
) (
  input  logic                                    UserCLK,
  input  logic                                    resetn,
  input  logic                                    s_valid,
  input  logic [FrameBitsPerRow-1:0]              s_data,
  output logic                                    s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]      FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0]   FrameStrobe,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int ColW = (NumColumns > 1) ? $clog2(NumColumns) : 1;
  localparam int FrmW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DISCARD,
    STROBE,
    SETTLE
  } state_t;

  state_t                                  state_q, state_d;
  logic [RowW-1:0]                         row_cnt_q, row_cnt_d;
  logic [ColW-1:0]                         col_q, col_d;
  logic [FrmW-1:0]                         frm_q, frm_d;
  logic [NumRows*FrameBitsPerRow-1:0]      frame_data_q, frame_data_d;
  logic [NumColumns*MaxFramesPerCol-1:0]   frame_strobe_q, frame_strobe_d;
  logic                                    done_q, done_d;
  logic                                    err_q, err_d;

  logic       xfer;
  logic       hdr_sync_ok;
  logic       hdr_range_ok;
  logic [7:0] hdr_col;
  logic [7:0] hdr_frm;

  // Ready is gated by resetn so nothing is accepted while reset is held.
  assign s_ready = resetn && (state_q == IDLE || state_q == LOAD || state_q == DISCARD);
  assign xfer    = s_valid && s_ready;

  assign hdr_col      = s_data[23:16];
  assign hdr_frm      = s_data[15:8];
  assign hdr_sync_ok  = (s_data[31:24] == 8'hA5);
  assign hdr_range_ok = (hdr_col < 8'(NumColumns)) && (hdr_frm < 8'(MaxFramesPerCol));

  always_comb begin
    state_d        = state_q;
    row_cnt_d      = row_cnt_q;
    col_d          = col_q;
    frm_d          = frm_q;
    frame_data_d   = frame_data_q;
    frame_strobe_d = '0;
    done_d         = 1'b0;
    err_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (!hdr_sync_ok) begin
            err_d = 1'b1;
          end else if (!hdr_range_ok) begin
            err_d     = 1'b1;
            state_d   = DISCARD;
            row_cnt_d = RowW'(NumRows - 1);
          end else begin
            col_d     = hdr_col[ColW-1:0];
            frm_d     = hdr_frm[FrmW-1:0];
            state_d   = LOAD;
            row_cnt_d = RowW'(NumRows - 1);
          end
        end
      end

      // Words arrive top row first, so the counter walks down to row 0.
      LOAD: begin
        if (xfer) begin
          for (int r = 0; r < NumRows; r++) begin
            if (row_cnt_q == RowW'(r)) begin
              frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
            end
          end
          if (row_cnt_q == '0) begin
            state_d = STROBE;
            for (int c = 0; c < NumColumns; c++) begin
              for (int f = 0; f < MaxFramesPerCol; f++) begin
                if (col_q == ColW'(c) && frm_q == FrmW'(f)) begin
                  frame_strobe_d[c*MaxFramesPerCol + f] = 1'b1;
                end
              end
            end
          end else begin
            row_cnt_d = row_cnt_q - 1'b1;
          end
        end
      end

      DISCARD: begin
        if (xfer) begin
          if (row_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            row_cnt_d = row_cnt_q - 1'b1;
          end
        end
      end

      STROBE: begin
        state_d = SETTLE;
      end

      SETTLE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      row_cnt_q      <= '0;
      col_q          <= '0;
      frm_q          <= '0;
      frame_data_q   <= '0;
      frame_strobe_q <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_cnt_q      <= row_cnt_d;
      col_q          <= col_d;
      frm_q          <= frm_d;
      frame_data_q   <= frame_data_d;
      frame_strobe_q <= frame_strobe_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign FrameData   = frame_data_q;
  assign FrameStrobe = frame_strobe_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Directed bench for frame_config_ctrl: drives header + data frames and checks
// FrameData contents, strobe position/timing, done/err pulses and reset behaviour.
module tb_frame_config_ctrl;

  localparam int FB = 32;
  localparam int MF = 20;
  localparam int NR = 16;
  localparam int NC = 8;

  logic                 UserCLK = 1'b0;
  logic                 resetn;
  logic                 s_valid;
  logic [FB-1:0]        s_data;
  logic                 s_ready;
  logic [NR*FB-1:0]     FrameData;
  logic [NC*MF-1:0]     FrameStrobe;
  logic                 busy;
  logic                 done;
  logic                 err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int   strobeCount = 0;
  int   strobeCycle = -100;
  int   strobeIdx = -1;
  int   doneCount = 0;
  int   doneCycle = -100;
  int   errCount = 0;
  int   readyLowCount = 0;
  logic readyAtDone = 1'b0;

  frame_config_ctrl #(
    .FrameBitsPerRow(FB),
    .MaxFramesPerCol(MF),
    .NumRows(NR),
    .NumColumns(NC)
  ) dut (
    .UserCLK(UserCLK),
    .resetn(resetn),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 UserCLK = ~UserCLK;

  always @(posedge UserCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] row(input int r);
    return FrameData[r*FB +: FB];
  endfunction

  // Sampled mid-cycle: records strobe/done/err events and enforces one-hot strobe.
  always @(negedge UserCLK) begin
    checkOutput("oneHot", 32'($countones(FrameStrobe) <= 1), 32'd1);
    checkOutput("doneErrExcl", {31'b0, done & err}, 32'd0);
    if (resetn && !s_ready) readyLowCount++;
    if (FrameStrobe != '0) begin
      strobeCount++;
      strobeCycle = cyc;
      for (int i = 0; i < NC*MF; i++) if (FrameStrobe[i]) strobeIdx = i;
      checkOutput("readyInStrobe", {31'b0, s_ready}, 32'd0);
    end
    if (cyc == strobeCycle + 1) checkOutput("readyInSettle", {31'b0, s_ready}, 32'd0);
    if (done) begin
      doneCount++;
      doneCycle = cyc;
      readyAtDone = s_ready;
    end
    if (err) errCount++;
  end

  task automatic applyStimulus(input logic [31:0] w, input bit gap, output int acc);
    bit got;
    acc = -1;
    if (gap) begin
      s_valid = 1'b0;
      @(posedge UserCLK);
      #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge UserCLK);
      if (s_ready) got = 1'b1;
    end
    if (got) begin
      acc = cyc;
      @(posedge UserCLK);
      #1;
    end else begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
    end
  endtask

  task automatic waitCycles(input int n);
    s_valid = 1'b0;
    s_data  = '0;
    repeat (n) @(posedge UserCLK);
    #1;
  endtask

  task automatic sendFrame(input logic [31:0] hdr, input logic [31:0] base, input bit gaps,
                           output int hdrCyc, output int lastCyc);
    applyStimulus(hdr, 1'b0, hdrCyc);
    for (int i = 0; i < NR; i++) begin
      applyStimulus(base + 32'(i), gaps ? 1'($urandom_range(0, 1)) : 1'b0, lastCyc);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int h, l, h2, l2, relCyc, rl0, sc;

    resetn  = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hA502_0500;
    repeat (3) @(posedge UserCLK);
    #1;
    checkOutput("rstReady", {31'b0, s_ready}, 32'd0);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstDone", {31'b0, done}, 32'd0);
    checkOutput("rstErr", {31'b0, err}, 32'd0);
    checkOutput("rstStrobe", {31'b0, |FrameStrobe}, 32'd0);
    checkOutput("rstData", {31'b0, |FrameData}, 32'd0);
    resetn = 1'b1;
    relCyc = cyc;

    // Basic frame: column 2, frame 5 -> strobe bit 45.
    sendFrame(32'hA502_0500, 32'h1000_0000, 1'b0, h, l);
    waitCycles(5);
    checkOutput("t1FirstAccept", 32'(h), 32'(relCyc));
    checkOutput("t1LoadCycles", 32'(l - h), 32'd16);
    checkOutput("t1StrobeLat", 32'(strobeCycle - l), 32'd1);
    checkOutput("t1DoneLat", 32'(doneCycle - l), 32'd3);
    checkOutput("t1StrobeCnt", 32'(strobeCount), 32'd1);
    checkOutput("t1StrobeIdx", 32'(strobeIdx), 32'd45);
    checkOutput("t1DoneCnt", 32'(doneCount), 32'd1);
    checkOutput("t1ReadyAtDone", {31'b0, readyAtDone}, 32'd1);
    checkOutput("t1Row15", row(15), 32'h1000_0000);
    checkOutput("t1Row7", row(7), 32'h1000_0008);
    checkOutput("t1Row0", row(0), 32'h1000_000F);
    checkOutput("t1ErrCnt", 32'(errCount), 32'd0);
    checkOutput("t1Busy", {31'b0, busy}, 32'd0);

    // Bad sync byte: err pulse, stays idle.
    applyStimulus(32'h5A00_0000, 1'b0, h);
    s_valid = 1'b0;
    checkOutput("t2ErrPulse", {31'b0, err}, 32'd1);
    checkOutput("t2Busy", {31'b0, busy}, 32'd0);
    waitCycles(2);
    checkOutput("t2ErrCnt", 32'(errCount), 32'd1);
    sendFrame(32'hA500_0000, 32'h2000_0000, 1'b0, h, l);
    waitCycles(5);
    checkOutput("t2StrobeIdx", 32'(strobeIdx), 32'd0);
    checkOutput("t2StrobeCnt", 32'(strobeCount), 32'd2);
    checkOutput("t2DoneCnt", 32'(doneCount), 32'd2);
    checkOutput("t2Row0", row(0), 32'h2000_000F);

    // Out-of-range column, then frame 20: both discarded.
    sendFrame(32'hA508_0000, 32'hDEAD_0000, 1'b0, h, l);
    waitCycles(3);
    checkOutput("t3aErrCnt", 32'(errCount), 32'd2);
    checkOutput("t3aBusy", {31'b0, busy}, 32'd0);
    sendFrame(32'hA500_1400, 32'hBEEF_0000, 1'b0, h, l);
    waitCycles(3);
    checkOutput("t3bErrCnt", 32'(errCount), 32'd3);
    checkOutput("t3StrobeCnt", 32'(strobeCount), 32'd2);
    checkOutput("t3DoneCnt", 32'(doneCount), 32'd2);
    checkOutput("t3Row0", row(0), 32'h2000_000F);
    checkOutput("t3Row15", row(15), 32'h2000_0000);

    // Random valid gaps: column 7, frame 19 -> bit 159.
    rl0 = readyLowCount;
    sendFrame(32'hA507_1300, 32'h3000_0000, 1'b1, h, l);
    waitCycles(5);
    checkOutput("t4StrobeIdx", 32'(strobeIdx), 32'd159);
    checkOutput("t4StrobeCnt", 32'(strobeCount), 32'd3);
    checkOutput("t4DoneLat", 32'(doneCycle - l), 32'd3);
    checkOutput("t4ReadyLow", 32'(readyLowCount - rl0), 32'd2);
    for (int r = 0; r < NR; r++) begin
      checkOutput($sformatf("t4Row%0d", r), row(r), 32'h3000_0000 + 32'(NR - 1 - r));
    end

    // Reset in the middle of a load.
    applyStimulus(32'hA503_0200, 1'b0, h);
    for (int i = 0; i < 8; i++) applyStimulus(32'h4000_0000 + 32'(i), 1'b0, l);
    sc = strobeCount;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t5Data", {31'b0, |FrameData}, 32'd0);
    checkOutput("t5Strobe", {31'b0, |FrameStrobe}, 32'd0);
    checkOutput("t5Busy", {31'b0, busy}, 32'd0);
    checkOutput("t5Done", {31'b0, done}, 32'd0);
    checkOutput("t5Err", {31'b0, err}, 32'd0);
    checkOutput("t5Ready", {31'b0, s_ready}, 32'd0);
    repeat (2) @(posedge UserCLK);
    #1;
    checkOutput("t5NoStrobe", 32'(strobeCount), 32'(sc));
    resetn = 1'b1;
    relCyc = cyc;
    sendFrame(32'hA503_0200, 32'h5000_0000, 1'b0, h, l);
    waitCycles(5);
    checkOutput("t5FirstAccept", 32'(h), 32'(relCyc));
    checkOutput("t5StrobeIdx", 32'(strobeIdx), 32'd62);
    checkOutput("t5StrobeCnt", 32'(strobeCount), 32'(sc + 1));
    checkOutput("t5Row0", row(0), 32'h5000_000F);
    checkOutput("t5Row8", row(8), 32'h5000_0007);

    // Back-to-back frames with valid held high.
    sc = strobeCount;
    sendFrame(32'hA501_0100, 32'h6000_0000, 1'b0, h, l);
    sendFrame(32'hA501_0200, 32'h7000_0000, 1'b0, h2, l2);
    waitCycles(5);
    checkOutput("t6HdrInDone", 32'(h2 - l), 32'd3);
    checkOutput("t6StrobeCnt", 32'(strobeCount), 32'(sc + 2));
    checkOutput("t6StrobeIdx", 32'(strobeIdx), 32'd22);
    checkOutput("t6Row15", row(15), 32'h7000_0000);
    checkOutput("t6Row0", row(0), 32'h7000_000F);
    checkOutput("t6ErrCnt", 32'(errCount), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_config_ctrl.md
Name: frame_config_ctrl

Overview:
- Configuration sequencer for one fabric region of tiles.
- Takes a 32-bit word stream (valid/ready) and assembles a full frame column across NumRows tile rows on the FrameData buses.
- Then issues a single-cycle one-hot FrameStrobe pulse for the selected column/frame.
- Sits between the bitstream source (UART/SPI loader) and the FrameData/FrameStrobe inputs of the tile array, including terminal tiles.

Parameters:
- FrameBitsPerRow, 32, width of FrameData per tile row; also the stream word width.
- MaxFramesPerCol, 20, frames per column; width of each column's FrameStrobe slice.
- NumRows, 16, tile rows driven; data words per frame.
- NumColumns, 8, tile columns driven.

Ports:
- UserCLK  input  1  configuration clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- s_valid  input  1  stream word valid.
- s_data  input  FrameBitsPerRow  stream word.
- s_ready  output  1  controller accepts the word this cycle.
- FrameData  output  NumRows*FrameBitsPerRow  row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  output  NumColumns*MaxFramesPerCol  column c occupies bits [c*MaxFramesPerCol +: MaxFramesPerCol].
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after a frame is strobed.
- err  output  1  one-cycle pulse on a rejected header.

Behaviour:
- Handshake:
  - A word transfers when s_valid && s_ready.
  - s_ready is combinational: high in IDLE, LOAD and DISCARD; low in STROBE and SETTLE and during reset.
  - s_data is ignored when there is no transfer.
- Header word:
  - [31:24] sync = 8'hA5; [23:16] column; [15:8] frame; [7:0] reserved, ignored.
- States: IDLE, LOAD, DISCARD, STROBE, SETTLE.
- IDLE, on transfer:
  - sync != A5: err pulse next cycle, stay IDLE (word dropped).
  - sync ok, column >= NumColumns or frame >= MaxFramesPerCol: err pulse, go to DISCARD, row_cnt = NumRows-1.
  - Otherwise: latch column/frame, go to LOAD, row_cnt = NumRows-1.
- LOAD:
  - Each transfer writes s_data into row row_cnt of FrameData. The first data word goes to the top row (NumRows-1); the last goes to row 0.
  - On the transfer with row_cnt == 0, go to STROBE.
  - s_valid gaps stall without side effects.
- DISCARD:
  - Consumes NumRows words exactly like LOAD, but FrameData is unchanged.
  - After the last word, go to IDLE; no strobe, no done.
- STROBE:
  - Exactly one cycle, with FrameStrobe bit (column*MaxFramesPerCol + frame) = 1 and all others 0.
  - Then go to SETTLE.
- SETTLE:
  - One cycle, FrameStrobe all 0, FrameData held.
  - Then IDLE; done pulses in the cycle IDLE is entered.
- FrameStrobe is registered, never has more than one bit set, and is 0 in every state except STROBE.
- FrameData is registered and holds its last value indefinitely; it is never cleared except by reset.
- Latency:
  - Last data word accepted in cycle T → strobe high in T+1 → SETTLE in T+2 → done high and s_ready high in T+3.
  - Minimum frame period is NumRows+3 cycles.
- Reset (asynchronous, any state, including mid-LOAD or during STROBE):
  - Outputs: FrameData=0, FrameStrobe=0, busy=0, done=0, err=0, s_ready=0 while resetn low.
  - Internal: state=IDLE, row_cnt=0, column/frame latches=0.
  - A partially loaded frame is lost and never strobed.
  - First acceptance is possible in the first clock after resetn deasserts.
- busy = (state != IDLE). done and err are never high in the same cycle.

Test Plan:
- Reset, then header A5_02_05_00 followed by 16 words 0x1000_0000+i (i=0..15) → row 15 = 0x1000_0000 and row 0 = 0x1000_000F; FrameStrobe bit 45 high for exactly 1 cycle; done 2 cycles later; total 19 cycles with continuous valid.
- Header 5A_00_00_00 → err pulse; state stays IDLE; next good header A5_00_00_00 plus 16 words → strobe bit 0.
- Header A5_08_00_00 (column out of range) and A5_00_14_00 (frame 20) each followed by 16 words → err pulse, no strobe, FrameData unchanged, next header accepted normally.
- Random s_valid gaps (~50%) during LOAD with header A5_07_13_00 → same FrameData as gap-free run; strobe bit 159 only; s_ready low exactly during the STROBE and SETTLE cycles.
- Assert resetn low after 8 data words of header A5_03_02_00 → all outputs 0 immediately, no strobe; after release, a full frame A5_03_02_00 completes with strobe bit 62.
- Two back-to-back frames with valid held high → second header accepted in the done cycle; FrameStrobe is never multi-hot.
